// File: rtl/div_arbiter.sv
//==============================================================================
// Module      : div_arbiter
// Description : Round-robin arbiter sharing one multi-cycle 16-bit signed
//               divider among NREQ requesters. Grants one pending request,
//               issues it to the divider, waits for done (with a watchdog),
//               and routes quotient/remainder back to the owning requester.
//               Optional macro DIV_ZERO_TRAP_EN short-circuits zero divisors
//               into an error response without touching the divider.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_arbiter #(
    parameter int NREQ    = 4,   // number of requesters, 2..8
    parameter int TIMEOUT = 64   // max WAIT cycles before abort, 20..255
) (
    input  logic                 clk,
    input  logic                 reset,
    // requester side
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_dividend,
    input  logic [16*NREQ-1:0]   req_divisor,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [15:0]          rsp_quotient,
    output logic [15:0]          rsp_remainder,
    output logic                 rsp_err,
    output logic                 busy,
    // divider side
    output logic                 div_start,
    output logic [15:0]          div_dividend,
    output logic [15:0]          div_divisor,
    input  logic                 div_done,
    input  logic [15:0]          div_quotient,
    input  logic [15:0]          div_remainder
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_TRAP  = 3'd4
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   owner_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [7:0]         timer_q;
    logic [NREQ-1:0]    gnt_q;
    logic [NREQ-1:0]    rsp_valid_q;
    logic [15:0]        rsp_quotient_q;
    logic [15:0]        rsp_remainder_q;
    logic               rsp_err_q;
    logic               div_start_q;
    logic [15:0]        div_dividend_q;
    logic [15:0]        div_divisor_q;

    // Arbitration result for the current IDLE cycle
    logic               sel_found_d;
    logic [PTR_W-1:0]   sel_idx_d;
    logic [15:0]        sel_dividend_d;
    logic [15:0]        sel_divisor_d;
    logic               sel_div_zero_d;

    // Round-robin scan starting just after the last owner; iterating from
    // the farthest candidate down lets the nearest set bit win.
    always_comb begin
        sel_found_d = 1'b0;
        sel_idx_d   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(ptr_q) + k) % NREQ]) begin
                sel_found_d = 1'b1;
                sel_idx_d   = PTR_W'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    // Operand mux for the selected requester
    always_comb begin
        sel_dividend_d = req_dividend[int'(sel_idx_d)*16 +: 16];
        sel_divisor_d  = req_divisor[int'(sel_idx_d)*16 +: 16];
        sel_div_zero_d = (sel_divisor_d == 16'd0);
    end

    // Main control FSM; every output it drives is registered and pulses are
    // cleared by default so each lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            owner_q         <= '0;
            ptr_q           <= PTR_W'(NREQ - 1);
            timer_q         <= '0;
            gnt_q           <= '0;
            rsp_valid_q     <= '0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_err_q       <= 1'b0;
            div_start_q     <= 1'b0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            div_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sel_found_d) begin
                        owner_q        <= sel_idx_d;
                        ptr_q          <= sel_idx_d;
                        div_dividend_q <= sel_dividend_d;
                        div_divisor_q  <= sel_divisor_d;
                        gnt_q          <= NREQ'(1) << sel_idx_d;
`ifdef DIV_ZERO_TRAP_EN
                        if (sel_div_zero_d) begin
                            // Zero divisor never reaches the divider.
                            state_q <= S_TRAP;
                        end else begin
                            div_start_q <= 1'b1;
                            state_q     <= S_ISSUE;
                        end
`else
                        div_start_q <= 1'b1;
                        state_q     <= S_ISSUE;
`endif
                    end
                end
                S_ISSUE: begin
                    // div_done is deliberately ignored here: it may still be
                    // high from the previous operation.
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (div_done) begin
                        rsp_quotient_q  <= div_quotient;
                        rsp_remainder_q <= div_remainder;
                        rsp_err_q       <= 1'b0;
                        rsp_valid_q     <= NREQ'(1) << owner_q;
                        state_q         <= S_RESP;
                    end else if (timer_q == TIMER_LAST) begin
                        rsp_quotient_q  <= '0;
                        rsp_remainder_q <= '0;
                        rsp_err_q       <= 1'b1;
                        rsp_valid_q     <= NREQ'(1) << owner_q;
                        state_q         <= S_RESP;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                S_TRAP: begin
                    rsp_quotient_q  <= '0;
                    rsp_remainder_q <= div_dividend_q;
                    rsp_err_q       <= 1'b1;
                    rsp_valid_q     <= NREQ'(1) << owner_q;
                    state_q         <= S_RESP;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt           = gnt_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_quotient  = rsp_quotient_q;
    assign rsp_remainder = rsp_remainder_q;
    assign rsp_err       = rsp_err_q;
    assign div_start     = div_start_q;
    assign div_dividend  = div_dividend_q;
    assign div_divisor   = div_divisor_q;
    assign busy          = (state_q != S_IDLE);

    // sel_div_zero_d only feeds the trap path; keep it referenced otherwise.
    logic unused_ok;
    assign unused_ok = sel_div_zero_d;

endmodule

`default_nettype wire

// File: tb/tb_div_arbiter.sv
//==============================================================================
// Module      : tb_div_arbiter
// Description : Directed self-checking bench for div_arbiter with a
//               behavioural divider raising done 17 cycles after start.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_div_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 24;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [16*NREQ-1:0]   req_dividend;
    logic [16*NREQ-1:0]   req_divisor;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      rsp_valid;
    logic [15:0]          rsp_quotient;
    logic [15:0]          rsp_remainder;
    logic                 rsp_err;
    logic                 busy;
    logic                 div_start;
    logic [15:0]          div_dividend;
    logic [15:0]          div_divisor;
    logic                 div_done;
    logic [15:0]          div_quotient;
    logic [15:0]          div_remainder;

    div_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .gnt           (gnt),
        .rsp_valid     (rsp_valid),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    always #5 clk = ~clk;

    // Behavioural divider: done is a level that rises 17 cycles after start
    // and stays high until the next start.
    logic               never_done;
    logic [4:0]         m_cnt;
    logic signed [15:0] m_a;
    logic signed [15:0] m_b;

    always @(posedge clk) begin
        if (reset) begin
            m_cnt         <= '0;
            m_a           <= '0;
            m_b           <= '0;
            div_done      <= 1'b0;
            div_quotient  <= '0;
            div_remainder <= '0;
        end else if (div_start) begin
            m_cnt    <= 5'd17;
            m_a      <= div_dividend;
            m_b      <= div_divisor;
            div_done <= 1'b0;
        end else if (m_cnt != 5'd0) begin
            m_cnt <= m_cnt - 5'd1;
            if (m_cnt == 5'd1 && !never_done) begin
                div_done <= 1'b1;
                if (m_b == 16'sd0) begin
                    div_quotient  <= 16'hFFFF;
                    div_remainder <= m_a;
                end else begin
                    div_quotient  <= m_a / m_b;
                    div_remainder <= m_a % m_b;
                end
            end
        end
    end

    // Per-cycle observation logs
    int              cyc;
    int              n_start;
    logic [NREQ-1:0] gnt_log[$];
    int              gnt_cyc[$];
    logic [NREQ-1:0] rv_log[$];
    logic [15:0]     rq_log[$];
    logic [15:0]     rr_log[$];
    logic            re_log[$];
    int              rsp_cyc[$];
    bit              drop_on_gnt;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic clear_logs();
        n_start = 0;
        gnt_log.delete(); gnt_cyc.delete();
        rv_log.delete(); rq_log.delete(); rr_log.delete(); re_log.delete(); rsp_cyc.delete();
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (|gnt) begin
            gnt_log.push_back(gnt);
            gnt_cyc.push_back(cyc);
            if (drop_on_gnt) req = req & ~gnt;
        end
        if (div_start) n_start++;
        if (|rsp_valid) begin
            rv_log.push_back(rsp_valid);
            rq_log.push_back(rsp_quotient);
            rr_log.push_back(rsp_remainder);
            re_log.push_back(rsp_err);
            rsp_cyc.push_back(cyc);
        end
    endtask

    task automatic wait_rsp(input string tag, input int n, input int max_cyc);
        int i = 0;
        while (rv_log.size() < n && i < max_cyc) begin
            step();
            i++;
        end
        check_val(tag, rv_log.size(), n);
    endtask

    task automatic wait_gnt(input string tag, input int n, input int max_cyc);
        int i = 0;
        while (gnt_log.size() < n && i < max_cyc) begin
            step();
            i++;
        end
        check_val(tag, gnt_log.size(), n);
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_dividend[i*16 +: 16] = a;
        req_divisor[i*16 +: 16]  = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        repeat (3) step();
        reset = 1'b0;
        clear_logs();
    endtask

    initial begin
        cyc          = 0;
        never_done   = 1'b0;
        drop_on_gnt  = 1'b1;
        req_dividend = '0;
        req_divisor  = '0;
        clear_logs();
        do_reset();

        // Reset state
        check_val("rst_gnt",   gnt, 0);
        check_val("rst_rspv",  rsp_valid, 0);
        check_val("rst_busy",  busy, 0);
        check_val("rst_start", div_start, 0);
        check_val("rst_q",     rsp_quotient, 0);
        check_val("rst_err",   rsp_err, 0);

        // 1: single request 100/7
        set_op(0, 16'd100, 16'd7);
        req = 4'b0001;
        wait_rsp("t1_rsp", 1, 60);
        check_val("t1_ngnt",  gnt_log.size(), 1);
        check_val("t1_gnt",   gnt_log[0], 4'b0001);
        check_val("t1_start", n_start, 1);
        check_val("t1_rv",    rv_log[0], 4'b0001);
        check_val("t1_q",     rq_log[0], 16'd14);
        check_val("t1_r",     rr_log[0], 16'd2);
        check_val("t1_err",   re_log[0], 0);
        check_val("t1_lat",   rsp_cyc[0] - gnt_cyc[0], 19);
        step();
        check_val("t1_busy",  busy, 0);

        // 2: all requesters held, 1000/-3 each
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 16'd1000, 16'hFFFD);
        drop_on_gnt = 1'b0;
        req = 4'b1111;
        wait_rsp("t2_rsp", 5, 200);
        req = '0;
        drop_on_gnt = 1'b1;
        check_val("t2_g0", gnt_log[0], 4'b0001);
        check_val("t2_g1", gnt_log[1], 4'b0010);
        check_val("t2_g2", gnt_log[2], 4'b0100);
        check_val("t2_g3", gnt_log[3], 4'b1000);
        check_val("t2_g4", gnt_log[4], 4'b0001);
        check_val("t2_rv1", rv_log[1], 4'b0010);
        check_val("t2_rv3", rv_log[3], 4'b1000);
        check_val("t2_q2",  rq_log[2], 16'hFEB3);
        check_val("t2_r4",  rr_log[4], 16'd1);
        check_val("t2_err", re_log[4], 0);

        // 3: divider never completes, -50/4 -> watchdog abort
        repeat (2) step();
        clear_logs();
        never_done = 1'b1;
        set_op(0, 16'hFFCE, 16'd4);
        req = 4'b0001;
        wait_rsp("t3_rsp", 1, 80);
        check_val("t3_lat", rsp_cyc[0] - gnt_cyc[0], TIMEOUT + 1);
        check_val("t3_q",   rq_log[0], 0);
        check_val("t3_r",   rr_log[0], 0);
        check_val("t3_err", re_log[0], 1);
        never_done = 1'b0;
        set_op(0, 16'd100, 16'd7);
        req = 4'b0001;
        wait_rsp("t3_next", 2, 60);
        check_val("t3_nq",   rq_log[1], 16'd14);
        check_val("t3_nerr", re_log[1], 0);

        // 4: reset asserted in WAIT
        repeat (2) step();
        clear_logs();
        req = 4'b0001;
        wait_gnt("t4_gnt", 1, 10);
        repeat (3) step();
        check_val("t4_busyw", busy, 1);
        reset = 1'b1;
        step();
        check_val("t4_busy",  busy, 0);
        check_val("t4_gnt",   gnt, 0);
        check_val("t4_rv",    rsp_valid, 0);
        check_val("t4_start", div_start, 0);
        check_val("t4_q",     rsp_quotient, 0);
        check_val("t4_dvd",   div_dividend, 0);
        step();
        reset = 1'b0;
        repeat (30) step();
        check_val("t4_norsp", rv_log.size(), 0);
        req = 4'b0010;
        wait_gnt("t4_g2", 2, 10);
        check_val("t4_first", gnt_log[1], 4'b0010);
        wait_rsp("t4_rsp", 1, 60);
        check_val("t4_rq", rq_log[0], 16'hFEB3);

        // 5: zero divisor from requester 2
        repeat (2) step();
        clear_logs();
        set_op(2, 16'd123, 16'd0);
        req = 4'b0100;
        wait_rsp("t5_rsp", 1, 60);
        check_val("t5_gnt", gnt_log[0], 4'b0100);
        check_val("t5_rv",  rv_log[0], 4'b0100);
        check_val("t5_r",   rr_log[0], 16'd123);
`ifdef DIV_ZERO_TRAP_EN
        check_val("t5_start", n_start, 0);
        check_val("t5_q",     rq_log[0], 0);
        check_val("t5_err",   re_log[0], 1);
`else
        check_val("t5_start", n_start, 1);
        check_val("t5_q",     rq_log[0], 16'hFFFF);
        check_val("t5_err",   re_log[0], 0);
`endif

        // 6: request arriving while busy waits for the next IDLE
        repeat (2) step();
        clear_logs();
        set_op(0, 16'd100, 16'd7);
        set_op(2, 16'd50, 16'd6);
        req = 4'b0001;
        wait_gnt("t6_g0", 1, 10);
        req = req | 4'b0100;
        wait_rsp("t6_rsp0", 1, 60);
        check_val("t6_ngnt", gnt_log.size(), 1);
        wait_gnt("t6_g2", 2, 10);
        check_val("t6_gid",  gnt_log[1], 4'b0100);
        check_val("t6_gap",  gnt_cyc[1] - rsp_cyc[0], 2);
        wait_rsp("t6_rsp2", 2, 60);
        check_val("t6_rv",   rv_log[1], 4'b0100);
        check_val("t6_q",    rq_log[1], 16'd8);
        check_val("t6_r",    rr_log[1], 16'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
